// File: rtl/cordic_seq_if.sv
// Handshake and control bundle between the host, the CORDIC sequencer and the rotation/scale datapath.
interface cordic_seq_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic             mode;
    logic             z_sign;
    logic             y_sign;
    logic             busy;
    logic             done;
    logic             dp_load;
    logic             dp_en;
    logic             dp_dir;
    logic [IDX_W-1:0] iter_idx;
    logic             mul_sel;
    logic             cap_x;
    logic             cap_y;

    modport master (
        output start, mode, z_sign, y_sign,
        input  busy, done, dp_load, dp_en, dp_dir, iter_idx, mul_sel, cap_x, cap_y
    );

    modport slave (
        input  start, mode, z_sign, y_sign,
        output busy, done, dp_load, dp_en, dp_dir, iter_idx, mul_sel, cap_x, cap_y
    );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC core: load, N_ITER micro-rotations, then x and y
// gain compensation through one shared multiplier, then a done pulse.
module cordic_seq_ctrl #(
    parameter int N_ITER  = 16,
    parameter int IDX_W   = 5,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    cordic_seq_if.slave  bus
);
    localparam int               WAIT_W    = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ITER - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MUL_LAT);

    typedef enum logic [2:0] {IDLE, LOAD, ROT, SCL_X, SCL_Y, DONE} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  iter, iter_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              mode_lat, mode_nx;

    always_comb begin
        state_nx = state;
        iter_nx  = iter;
        wait_nx  = wait_cnt;
        mode_nx  = mode_lat;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    mode_nx  = bus.mode;
                end
            end
            LOAD: begin
                state_nx = ROT;
                iter_nx  = '0;
            end
            ROT: begin
                if (iter == LAST_IDX) begin
                    state_nx = SCL_X;
                    iter_nx  = '0;
                    wait_nx  = '0;
                end else begin
                    iter_nx = iter + IDX_W'(1);
                end
            end
            SCL_X: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_nx = SCL_Y;
                    wait_nx  = '0;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            SCL_Y: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_nx = DONE;
                    wait_nx  = '0;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    mode_nx  = bus.mode;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            iter        <= '0;
            wait_cnt    <= '0;
            mode_lat    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.dp_load <= 1'b0;
            bus.dp_en   <= 1'b0;
            bus.mul_sel <= 1'b0;
            bus.cap_x   <= 1'b0;
            bus.cap_y   <= 1'b0;
        end else begin
            state       <= state_nx;
            iter        <= iter_nx;
            wait_cnt    <= wait_nx;
            mode_lat    <= mode_nx;
            bus.busy    <= (state_nx != IDLE);
            bus.done    <= (state_nx == DONE);
            bus.dp_load <= (state_nx == LOAD);
            bus.dp_en   <= (state_nx == ROT);
            bus.mul_sel <= (state_nx == SCL_Y);
            bus.cap_x   <= (state_nx == SCL_X) && (wait_nx == LAST_WAIT);
            bus.cap_y   <= (state_nx == SCL_Y) && (wait_nx == LAST_WAIT);
        end
    end

    assign bus.iter_idx = iter;

    // Direction follows the live sign bit so the datapath sees it in the same ROT cycle.
    assign bus.dp_dir = (state == ROT) && (mode_lat ? bus.y_sign : ~bus.z_sign);
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: nominal and edge-parameter instances, expected
// values from the documented cycle timing.
module tb_cordic_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic exp_dir;

    always #5 clk = ~clk;

    cordic_seq_if #(.IDX_W(5)) a ();
    cordic_seq_if #(.IDX_W(5)) b ();

    cordic_seq_ctrl #(.N_ITER(16), .IDX_W(5), .MUL_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    cordic_seq_ctrl #(.N_ITER(1),  .IDX_W(5), .MUL_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    // {busy, done, dp_load, dp_en, mul_sel, cap_x, cap_y, iter_idx}
    logic [11:0] obs_a, obs_b;
    assign obs_a = {a.busy, a.done, a.dp_load, a.dp_en, a.mul_sel, a.cap_x, a.cap_y, a.iter_idx};
    assign obs_b = {b.busy, b.done, b.dp_load, b.dp_en, b.mul_sel, b.cap_x, b.cap_y, b.iter_idx};

    function automatic logic [11:0] model(int c, int n, int l);
        logic busy, done, load, en, msel, cx, cy;
        logic [4:0] idx;
        done = (c == n + 4 + 2 * l);
        busy = (c >= 1) && (c <= n + 4 + 2 * l);
        load = (c == 1);
        en   = (c >= 2) && (c <= n + 1);
        idx  = en ? 5'(c - 2) : 5'd0;
        msel = (c >= n + 3 + l) && (c <= n + 3 + 2 * l);
        cx   = (c == n + 2 + l);
        cy   = (c == n + 3 + 2 * l);
        return {busy, done, load, en, msel, cx, cy, idx};
    endfunction

    task automatic check(input string tag, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, c, act, exp);
    endtask

    initial begin
        a.start = 0; a.mode = 0; a.z_sign = 0; a.y_sign = 0;
        b.start = 0; b.mode = 0; b.z_sign = 0; b.y_sign = 0;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_a", c, 32'(obs_a), 32'd0);
            check("idle_b", c, 32'(obs_b), 32'd0);
            check("idle_dir", c, 32'(a.dp_dir), 32'd0);
        end

        // Nominal sequence
        @(negedge clk);
        a.start = 1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) a.start = 0;
            check("nominal", c, 32'(obs_a), 32'(model(c, 16, 2)));
        end

        // Rotation mode: direction from ~z_sign
        @(negedge clk);
        a.start = 1; a.mode = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) a.start = 0;
            if (c >= 2 && c <= 17) begin
                a.z_sign = (c % 2 == 0);
                #1;
                exp_dir = (c % 2 != 0);
                check("dir_rot", c, 32'(a.dp_dir), 32'(exp_dir));
            end
        end

        // Vectoring mode: direction from y_sign, mode change mid-op ignored
        a.z_sign = 1;
        @(negedge clk);
        a.start = 1; a.mode = 1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) begin a.start = 0; a.mode = 0; end
            if (c >= 2 && c <= 17) begin
                a.y_sign = (c % 3 == 0);
                #1;
                exp_dir = (c % 3 == 0);
                check("dir_vec", c, 32'(a.dp_dir), 32'(exp_dir));
            end
            if (c == 20) check("dir_scl", c, 32'(a.dp_dir), 32'd0);
        end
        a.y_sign = 0; a.z_sign = 0;

        // Start held high while busy: only accepted in DONE
        @(negedge clk);
        a.start = 1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 31) a.start = 0;
            if (c <= 31) check("busy_load", c, 32'(a.dp_load), 32'((c == 1) || (c == 25)));
            if (c == 24 || c == 48) check("busy_done", c, 32'(a.done), 32'd1);
        end
        check("busy_idle", 50, 32'(obs_a), 32'd0);

        // Reset mid-operation
        @(negedge clk);
        a.start = 1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) a.start = 0;
            if (c <= 10) check("pre_rst", c, 32'(obs_a), 32'(model(c, 16, 2)));
            else check("post_rst", c, 32'(obs_a), 32'd0);
            if (c == 10) rst = 1;
            if (c == 11) rst = 0;
        end
        @(negedge clk);
        a.start = 1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) a.start = 0;
            check("rerun", c, 32'(obs_a), 32'(model(c, 16, 2)));
        end

        // Edge parameters: N_ITER=1, MUL_LAT=0
        @(negedge clk);
        b.start = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) b.start = 0;
            check("edge", c, 32'(obs_b), 32'(model(c, 1, 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
